edge_capture_bank: RTL and testbench
====================================

// Module: edge_capture_bank
// PURPOSE
//   Multi-channel edge capture: per-channel programmable edge mode, sticky
//   event flags with write-1-to-clear, overrun detection, masked interrupt.
//   Sits between external/peripheral strobes and the Z80 interrupt logic;
//   the CPU-side register wrapper drives mode/mask/clr and reads flags/ovf.
// PARAMETERS
//   CHANNELS  8  number of independent input channels (1..32)
// PORTS
//   clk      in   1           system clock, all logic on posedge
//   rst_n    in   1           asynchronous active-low reset
//   sig      in   CHANNELS    monitored inputs, bit i = channel i
//   mode     in   2*CHANNELS  per-channel mode, bits [2i+1:2i]
//   mask     in   CHANNELS    1 = channel contributes to irq
//   clr      in   CHANNELS    1-cycle pulse, write-1-to-clear flag and ovf
//   flags    out  CHANNELS    sticky edge-detected flags
//   ovf      out  CHANNELS    sticky overrun: edge seen while flag already set
//   irq      out  1           registered OR of (flags & mask)
// BEHAVIOUR
//   - Reset (rst_n=0, async): flags=0, ovf=0, irq=0, inited=0, history=0.
//   - Mode per channel: 00 off, 01 rising, 10 falling, 11 both edges.
//   - Baseline: first posedge after reset release loads history<=sig_s,
//     sets inited; no edge is detected on that cycle (no false edge from
//     reset-time level). Every subsequent cycle history<=sig_s.
//   - sig_s = sig (macro off) or synchronised sig (macro on).
//   - Edge(i) = inited & match(mode[i], history[i], sig_s[i]);
//     rise = ~hist&cur, fall = hist&~cur.
//   - Latency: sig_s change at posedge n is compared at n, flags[i]=1
//     visible after posedge n; irq follows flags one cycle later.
//   - flags[i] next: edge -> 1; else clr[i] -> 0; else hold.
//     Simultaneous edge and clr: flag stays 1 (set wins), ovf unchanged.
//   - ovf[i] next: clr[i] & ~edge -> 0; edge & flags[i] & ~clr[i] -> 1;
//     else hold. ovf never sets without a prior unacknowledged flag.
//   - mode change takes effect on the next compare; history keeps
//     tracking while mode=00, so re-enabling never reports a stale edge.
//   - Changing mode to 00 does not clear flags/ovf; only clr or reset does.
//   - clr on a channel with flags=0 is a no-op.
//   - mask affects irq only, never flags/ovf.
//   - Reset mid-operation: all state clears immediately (async), baseline
//     cycle repeats after release.
//   - Channels fully independent; no cross-channel priority.
// CONFIGURATION
//   EDGE_CAPTURE_SYNC_EN
//     defined:   each sig bit passes a 2-FF synchroniser (reset to 0) before
//                history/compare; edge-to-flag latency +2 cycles; the
//                baseline cycle is delayed until the synchroniser has been
//                loaded (inited sets on the 3rd posedge after release).
//     undefined: sig used directly (caller guarantees clk-domain inputs);
//                inited sets on the 1st posedge after release.
// TESTING
//   1 CHANNELS=8, macro off, sig=8'hFF held through reset, mode all 01
//     -> release: flags stay 8'h00 (no false edge from baseline).
//   2 mode[1:0]=01, sig[0] 0->1 at cycle 5 -> flags[0]=1 after cycle 5,
//     irq=1 after cycle 6 with mask[0]=1; irq stays 0 with mask[0]=0.
//   3 mode[3:2]=11, sig[1] toggles 0->1->0 with clr idle -> flags[1]=1,
//     ovf[1]=1 on second edge; clr=8'h02 -> flags[1]=0, ovf[1]=0.
//   4 mode[5:4]=10, falling edge on sig[2] coincident with clr[2]=1
//     -> flags[2]=1, ovf[2]=0.
//   5 flags=8'h0F, assert rst_n=0 mid-cycle -> flags, ovf, irq 0
//     asynchronously; edge on release cycle not reported.
//   6 macro on: sig[3] rising, mode 01 -> flags[3] rises 3 cycles after
//     sig change (2 sync + 1 compare).

Source files
------------

// File: rtl/edge_capture_bank.sv
// Multi-channel edge capture with sticky write-1-to-clear flags, overrun detection and a masked irq.
// Define EDGE_CAPTURE_SYNC_EN to pass every sig bit through a 2-FF synchroniser before edge detection.
module edge_capture_bank #(
    parameter int CHANNELS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   sig,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   mask,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   flags,
    output logic [CHANNELS-1:0]   ovf,
    output logic                  irq
);

    logic [CHANNELS-1:0] sig_s;
    logic                inited_load;

`ifdef EDGE_CAPTURE_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [1:0]          init_cnt_q, init_cnt_d;

    // The baseline waits until both synchroniser stages hold post-reset samples.
    always_comb begin
        sync1_d    = sig;
        sync2_d    = sync1_q;
        init_cnt_d = init_cnt_q;
        if (init_cnt_q != 2'd2) begin
            init_cnt_d = init_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            init_cnt_q <= 2'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign sig_s       = sync2_q;
    assign inited_load = (init_cnt_q == 2'd2);
`else
    assign sig_s       = sig;
    assign inited_load = 1'b1;
`endif

    logic [CHANNELS-1:0] hist_q, hist_d;
    logic                inited_q, inited_d;
    logic [CHANNELS-1:0] flags_q, flags_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                irq_q, irq_d;
    logic [CHANNELS-1:0] rise_vec, fall_vec, edge_hit;

    assign rise_vec = ~hist_q & sig_s;
    assign fall_vec = hist_q & ~sig_s;

    // Edges are only reported once the history register holds a real sample.
    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode[2*i +: 2])
                2'b01:   edge_hit[i] = inited_q & rise_vec[i];
                2'b10:   edge_hit[i] = inited_q & fall_vec[i];
                2'b11:   edge_hit[i] = inited_q & (rise_vec[i] | fall_vec[i]);
                default: edge_hit[i] = 1'b0;
            endcase
        end
    end

    // A new edge beats a same-cycle clear; overrun only arms on an unacknowledged flag.
    always_comb begin
        hist_d   = sig_s;
        inited_d = inited_q | inited_load;
        flags_d  = edge_hit | (flags_q & ~clr);
        ovf_d    = (ovf_q & ~(clr & ~edge_hit)) | (edge_hit & flags_q & ~clr);
        irq_d    = |(flags_q & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q   <= '0;
            inited_q <= 1'b0;
            flags_q  <= '0;
            ovf_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            inited_q <= inited_d;
            flags_q  <= flags_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    assign flags = flags_q;
    assign ovf   = ovf_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_edge_capture_bank.sv
// Scoreboard bench for edge_capture_bank: directed scenarios followed by randomized traffic,
// each cycle's expected flags/ovf/irq come from a per-channel behavioural model.
module tb_edge_capture_bank;

    localparam int N = 8;
`ifdef EDGE_CAPTURE_SYNC_EN
    localparam int SETTLE = 3;
    localparam bit SYNC   = 1'b1;
`else
    localparam int SETTLE = 1;
    localparam bit SYNC   = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   sig;
    logic [2*N-1:0] mode;
    logic [N-1:0]   mask;
    logic [N-1:0]   clr;
    logic [N-1:0]   flags;
    logic [N-1:0]   ovf;
    logic           irq;

    edge_capture_bank #(.CHANNELS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig),
        .mode  (mode),
        .mask  (mask),
        .clr   (clr),
        .flags (flags),
        .ovf   (ovf),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] flags;
        logic [N-1:0] ovf;
        logic         irq;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: last sampled level per channel, sticky bits, a delay line for the synchroniser.
    bit     m_prev  [N];
    bit     m_flag  [N];
    bit     m_ovf   [N];
    bit     m_irq;
    logic [N-1:0] pipe0, pipe1;
    int     since_rel;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 1'b0;
            m_flag[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
        m_irq     = 1'b0;
        pipe0     = '0;
        pipe1     = '0;
        since_rel = 0;
    endtask

    task automatic modelStep();
        exp_t         e;
        logic [N-1:0] cur;
        bit           allowed, rise, fall, hit, any;
        int           md;
        if (!rst_n) begin
            modelReset();
        end else begin
            cur     = SYNC ? pipe1 : sig;
            allowed = (since_rel >= SETTLE);
            any     = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_flag[i] && mask[i]) any = 1'b1;
            end
            m_irq = any;
            for (int i = 0; i < N; i++) begin
                md   = int'(mode[2*i +: 2]);
                rise = !m_prev[i] && cur[i];
                fall = m_prev[i] && !cur[i];
                hit  = allowed && ((md == 1 && rise) || (md == 2 && fall) || (md == 3 && (rise || fall)));
                if (hit) begin
                    if (m_flag[i] && !clr[i]) m_ovf[i] = 1'b1;
                    m_flag[i] = 1'b1;
                end else if (clr[i]) begin
                    m_flag[i] = 1'b0;
                    m_ovf[i]  = 1'b0;
                end
                m_prev[i] = cur[i];
            end
            pipe1 = pipe0;
            pipe0 = sig;
            if (since_rel < 100) since_rel++;
        end
        for (int i = 0; i < N; i++) begin
            e.flags[i] = m_flag[i];
            e.ovf[i]   = m_ovf[i];
        end
        e.irq = m_irq;
        sb_q.push_back(e);
    endtask

    // Drives one cycle of inputs at the falling edge; a fresh reset assertion is checked asynchronously.
    task automatic applyStimulus(input logic r, input logic [N-1:0] s, input logic [2*N-1:0] m,
                                 input logic [N-1:0] mk, input logic [N-1:0] c);
        @(negedge clk);
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            checkOutput("async_rst_flags", 32'(flags), 32'd0);
            checkOutput("async_rst_ovf", 32'(ovf), 32'd0);
            checkOutput("async_rst_irq", 32'(irq), 32'd0);
        end else begin
            rst_n = r;
        end
        sig  = s;
        mode = m;
        mask = mk;
        clr  = c;
        modelStep();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("flags", 32'(flags), 32'(e.flags));
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            checkOutput("irq", 32'(irq), 32'(e.irq));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [N-1:0]   s, mk, c;
        logic [2*N-1:0] m;
        int             rst_left;
        rst_n = 1'b0;
        sig   = 8'hFF;
        mode  = 16'h5555;
        mask  = '0;
        clr   = '0;
        modelReset();

        // High inputs held through reset must not look like edges after release.
        repeat (3) applyStimulus(1'b0, 8'hFF, 16'h5555, 8'h00, 8'h00);
        repeat (6) applyStimulus(1'b1, 8'hFF, 16'h5555, 8'h00, 8'h00);

        // Rising edge on channel 0, first unmasked then masked in.
        repeat (3) applyStimulus(1'b1, 8'h00, 16'h0001, 8'h00, 8'h00);
        repeat (4) applyStimulus(1'b1, 8'h01, 16'h0001, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h01, 16'h0001, 8'h00, 8'h01);
        applyStimulus(1'b1, 8'h00, 16'h0001, 8'h01, 8'h00);
        repeat (4) applyStimulus(1'b1, 8'h01, 16'h0001, 8'h01, 8'h00);

        // Both-edge mode on channel 1 builds an overrun, then a clear drops it.
        applyStimulus(1'b1, 8'h00, 16'h000C, 8'h02, 8'h01);
        applyStimulus(1'b1, 8'h02, 16'h000C, 8'h02, 8'h00);
        applyStimulus(1'b1, 8'h00, 16'h000C, 8'h02, 8'h00);
        repeat (2) applyStimulus(1'b1, 8'h00, 16'h000C, 8'h02, 8'h00);
        applyStimulus(1'b1, 8'h00, 16'h000C, 8'h02, 8'h02);
        repeat (2) applyStimulus(1'b1, 8'h00, 16'h000C, 8'h02, 8'h00);

        // Falling edge on channel 2 coincident with its clear.
        repeat (4) applyStimulus(1'b1, 8'h04, 16'h0020, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h00, 16'h0020, 8'h00, 8'h04);
        repeat (3) applyStimulus(1'b1, 8'h00, 16'h0020, 8'h00, 8'h00);

        // Four flags set, then reset mid-cycle and an edge during the release cycle.
        applyStimulus(1'b1, 8'h00, 16'h5555, 8'h0F, 8'hFF);
        repeat (4) applyStimulus(1'b1, 8'h0F, 16'h5555, 8'h0F, 8'h00);
        repeat (2) applyStimulus(1'b0, 8'h00, 16'h5555, 8'h0F, 8'h00);
        applyStimulus(1'b1, 8'hF0, 16'h5555, 8'h0F, 8'h00);
        repeat (5) applyStimulus(1'b1, 8'hF0, 16'h5555, 8'h0F, 8'h00);

        s        = 8'hF0;
        m        = 16'h5555;
        mk       = 8'h0F;
        rst_left = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 63) == 0) m = 16'($urandom);
            if ($urandom_range(0, 31) == 0) mk = 8'($urandom);
            s = s ^ 8'($urandom & $urandom);
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 2;
            if (rst_left > 0) begin
                applyStimulus(1'b0, s, m, mk, c);
                rst_left--;
            end else begin
                applyStimulus(1'b1, s, m, mk, c);
            end
        end

        @(posedge clk);
        #3;
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
